// File: rtl/ppm_pkg.sv
// ppm_pkg: shared types and default constants for the PPM frame decoder
package ppm_pkg;
  localparam int CODE_W = 16;
  localparam int NCH_DEF = 8;
  localparam logic [CODE_W-1:0] SYNC_MIN_DEF = 16'd5000;
  localparam logic [CODE_W-1:0] MIN_W_DEF = 16'd800;
  localparam logic [CODE_W-1:0] MAX_W_DEF = 16'd2400;
  localparam logic [23:0] TIMEOUT_DEF = 24'd2000000;
  typedef enum logic [1:0] {HUNT, CHAN, WAIT_SYNC} ppm_state_e;
endpackage

// File: rtl/ppm_watchdog.sv
// ppm_watchdog: idle counter that flags link loss when VALID stops arriving
module ppm_watchdog
  import ppm_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic VALID,
  input  logic COMMIT,
  output logic LOST_EVT,
  output logic LOST
);
  logic [23:0] cnt;
  // A strobe in the reaching cycle wins, so the event only fires on an idle cycle
  assign LOST_EVT = !VALID && cnt == TIMEOUT - 24'd1;
  // Count idle cycles up to TIMEOUT; LOST is set on timeout and cleared by a commit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
      LOST <= 1'b1;
    end else begin
      cnt <= VALID ? '0 : (cnt >= TIMEOUT ? cnt : cnt + 24'd1);
      LOST <= LOST_EVT ? 1'b1 : (COMMIT ? 1'b0 : LOST);
    end
  end
endmodule

// File: rtl/ppm_frame_decoder.sv
// ppm_frame_decoder: classifies PPM pulse codes, assembles frames and commits them atomically
module ppm_frame_decoder
  import ppm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter logic [CODE_W-1:0] SYNC_MIN = SYNC_MIN_DEF,
  parameter logic [CODE_W-1:0] MIN_W = MIN_W_DEF,
  parameter logic [CODE_W-1:0] MAX_W = MAX_W_DEF,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [CODE_W-1:0] CODE,
  input  logic              VALID,
  input  logic [3:0]        CH_SEL,
  output logic [CODE_W-1:0] CH_VALUE,
  output logic              FRAME_VALID,
  output logic [7:0]        FRAME_CNT,
  output logic [7:0]        ERR_CNT,
  output logic              LOST
);
  localparam logic [3:0] LAST = 4'(NCH - 1);
  localparam logic [4:0] NCH5 = 5'(NCH);
  ppm_state_e state, state_n;
  logic [3:0] idx, idx_n;
  logic [CODE_W-1:0] shadow [16];
  logic [CODE_W-1:0] committed [16];
  logic is_sync, is_chan, wr, clr, commit, err, lost_evt;
  assign is_sync = VALID && CODE >= SYNC_MIN;
  assign is_chan = VALID && CODE >= MIN_W && CODE <= MAX_W;
  ppm_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .COMMIT(commit),
    .LOST_EVT(lost_evt), .LOST(LOST)
  );
  // Next-state and datapath controls; any non-SYNC, non-CHAN strobe is BAD
  always_comb begin
    state_n = state;
    idx_n = idx;
    wr = 1'b0;
    clr = 1'b0;
    commit = 1'b0;
    err = 1'b0;
    case (state)
      HUNT: if (is_sync) begin
        state_n = CHAN;
        idx_n = '0;
      end
      CHAN: if (is_chan) begin
        wr = 1'b1;
        idx_n = idx == LAST ? '0 : idx + 4'd1;
        state_n = idx == LAST ? WAIT_SYNC : CHAN;
      end else if (is_sync) begin
        err = 1'b1;
        clr = 1'b1;
        idx_n = '0;
      end else if (VALID) begin
        err = 1'b1;
        state_n = HUNT;
        idx_n = '0;
      end
      WAIT_SYNC: if (is_sync) begin
        commit = 1'b1;
        state_n = CHAN;
        idx_n = '0;
      end else if (VALID) begin
        err = 1'b1;
        state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
    if (lost_evt) begin
      state_n = HUNT;
      idx_n = '0;
    end
  end
  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= HUNT;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  // Shadow capture, atomic commit, readout and frame/error counters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow <= '{default: '0};
      committed <= '{default: '0};
      CH_VALUE <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_CNT <= '0;
      ERR_CNT <= '0;
    end else begin
      if (clr) shadow <= '{default: '0};
      else if (wr) shadow[idx] <= CODE;
      if (commit) committed <= shadow;
      CH_VALUE <= {1'b0, CH_SEL} < NCH5 ? committed[CH_SEL] : '0;
      FRAME_VALID <= commit;
      FRAME_CNT <= commit ? FRAME_CNT + 8'd1 : FRAME_CNT;
      ERR_CNT <= err && ERR_CNT != 8'hFF ? ERR_CNT + 8'd1 : ERR_CNT;
    end
  end
endmodule
